// File: rtl/rng_pkg.sv
// Shared types and defaults for the TRNG burst scheduler.
// STATE readback uses the rng_state_e encoding directly.
package rng_pkg;

  localparam int RNG_CNT_W   = 32;
  localparam int RNG_BURST_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_ARM    = 3'd3,
    ST_STREAM = 3'd4,
    ST_GAP    = 3'd5,
    ST_FAIL   = 3'd6
  } rng_state_e;

endpackage

// File: rtl/rng_cyc_timer.sv
// Loadable down-counter with a zero flag.
// The warm-up and inter-burst gap intervals share this one instance.
module rng_cyc_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the counter rests at zero.
  always_comb begin
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/rng_burst_sched.sv
// Burst scheduler driving the RNG controller GO/STOP/SEND_BYTES handshake:
// optional warm-up, then bursts separated by gaps, aborting on overflow or ABORT.
module rng_burst_sched
  import rng_pkg::*;
#(
  parameter int CNT_W   = RNG_CNT_W,
  parameter int BURST_W = RNG_BURST_W
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               START,
  input  logic               ABORT,
  input  logic [CNT_W-1:0]   WARMUP_CYC,
  input  logic [CNT_W-1:0]   BURST_BYTES,
  input  logic [BURST_W-1:0] NUM_BURSTS,
  input  logic [CNT_W-1:0]   GAP_CYC,
  output logic               GO,
  output logic               STOP,
  output logic [CNT_W-1:0]   SEND_BYTES,
  input  logic               RUN,
  input  logic               OVER,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [BURST_W-1:0] BURST_CNT,
  output logic [CNT_W-1:0]   TOTAL_BYTES,
  output logic [2:0]         STATE
);

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_MAX  = {BURST_W{1'b1}};

  rng_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bytes_q, bytes_d, gap_q, gap_d, tot_q, tot_d;
  logic [BURST_W-1:0] num_q, num_d, bcnt_q, bcnt_d, bcnt_inc;
  logic               done_q, done_d, err_q, err_d, abort_q, abort_d;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;
  logic               cfg_bad;

  assign cfg_bad  = (BURST_BYTES == CNT_ZERO) || (BURST_BYTES[1:0] != 2'b00);
  assign bcnt_inc = (bcnt_q == BURST_MAX) ? bcnt_q : bcnt_q + BURST_ONE;

  rng_cyc_timer #(.W(CNT_W)) u_timer (
    .clk_i  (CLK),
    .rst_ni (RST_X),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .en_i   (tmr_en),
    .zero_o (tmr_zero)
  );

  // Sequencer next-state; interval timers are loaded with N-1 so each interval lasts N cycles.
  always_comb begin
    state_d  = state_q;
    bytes_d  = bytes_q;
    gap_d    = gap_q;
    num_d    = num_q;
    tot_d    = tot_q;
    bcnt_d   = bcnt_q;
    done_d   = done_q;
    err_d    = err_q;
    abort_d  = abort_q;
    tmr_load = 1'b0;
    tmr_val  = CNT_ZERO;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            bytes_d = BURST_BYTES;
            gap_d   = GAP_CYC;
            num_d   = NUM_BURSTS;
            tot_d   = CNT_ZERO;
            bcnt_d  = BURST_ZERO;
            done_d  = 1'b0;
            err_d   = 1'b0;
            abort_d = 1'b0;
            if (WARMUP_CYC == CNT_ZERO) begin
              state_d = ST_CLEAR;
            end else begin
              state_d  = ST_WARMUP;
              tmr_load = 1'b1;
              tmr_val  = WARMUP_CYC - CNT_ONE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WARMUP, ST_GAP: begin
        if (tmr_zero) begin
          state_d = ST_CLEAR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_CLEAR: state_d = ST_ARM;
      ST_ARM:   state_d = ST_STREAM;
      ST_STREAM: begin
        if (OVER) begin
          state_d = ST_FAIL;
        end else if (!RUN) begin
          bcnt_d = bcnt_inc;
          tot_d  = tot_q + bytes_q;
          if ((num_q != BURST_ZERO) && (bcnt_inc == num_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (gap_q == CNT_ZERO) begin
            state_d = ST_CLEAR;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = gap_q - CNT_ONE;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_FAIL: begin
        err_d   = err_q | ~abort_q;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // ABORT overrides everything decided above, leaving counters and flags untouched.
    if (ABORT && (state_q != ST_IDLE)) begin
      bcnt_d = bcnt_q;
      tot_d  = tot_q;
      done_d = done_q;
      err_d  = err_q;
      if (state_q == ST_FAIL) begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end else begin
        abort_d = 1'b1;
        state_d = ST_FAIL;
      end
    end else begin
      abort_d = abort_d;
    end
  end

  // Sequencer state and status registers.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= ST_IDLE;
      bytes_q <= CNT_ZERO;
      gap_q   <= CNT_ZERO;
      num_q   <= BURST_ZERO;
      tot_q   <= CNT_ZERO;
      bcnt_q  <= BURST_ZERO;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bytes_q <= bytes_d;
      gap_q   <= gap_d;
      num_q   <= num_d;
      tot_q   <= tot_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign GO          = (state_q == ST_ARM);
  assign STOP        = (state_q == ST_CLEAR) || (state_q == ST_FAIL);
  assign SEND_BYTES  = (state_q == ST_ARM) ? bytes_q : CNT_ZERO;
  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign BURST_CNT   = bcnt_q;
  assign TOTAL_BYTES = tot_q;
  assign STATE       = state_q;

endmodule
